// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg
// Shared definitions for the SPI NOR flash read engine:
//   - flash opcodes (normal read, fast read, release power-down)
//   - top-level state enumeration
//   - bit counts of the dummy and data phases
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_WAKE      = 8'hAB;

    localparam int DUMMY_BITS = 8;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_STREAM,
        ST_GAP
    } state_t;

endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine
// Mode-0 SPI bit engine. A start pulse loads up to 32 MSB-aligned bits and a
// bit count; each bit is CLK_DIV clk cycles with SCLK low (MOSI changes on
// the first of them) followed by CLK_DIV cycles with SCLK high (MISO sampled
// at the end of the first high cycle).
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   i_start         load i_data/i_nbits and begin shifting next cycle
//   i_data          bits to send, MSB-aligned
//   i_nbits         number of bits to send (1..32)
//   i_miso          serial input
//   o_sclk, o_mosi  registered SPI clock / data out
//   o_done          high during the last clk cycle of the last bit; a start
//                   issued in that cycle continues without any idle cycle
//   o_rx            last 8 bits received
module spi_shift_engine #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic [31:0] i_data,
    input  logic [5:0]  i_nbits,
    input  logic        i_miso,
    output logic        o_sclk,
    output logic        o_mosi,
    output logic        o_done,
    output logic [7:0]  o_rx
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             r_active;
    logic             r_phase;   // 0 = SCLK low half, 1 = SCLK high half
    logic [DIV_W-1:0] r_div;
    logic [31:0]      r_shift;
    logic [5:0]       r_bits;
    logic [7:0]       r_rx;
    logic             r_sclk;
    logic             r_mosi;
    logic             w_div_end;

    assign w_div_end = (r_div == DIV_LAST);
    assign o_done    = r_active && r_phase && w_div_end && (r_bits == 6'd1);
    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;
    assign o_rx      = r_rx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_phase  <= 1'b0;
            r_div    <= '0;
            r_shift  <= '0;
            r_bits   <= '0;
            r_rx     <= '0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
        end else begin
            // Sampling is independent of a reload so the final bit of a
            // segment is still captured when the next segment starts.
            if (r_active && r_phase && (r_div == '0)) begin
                r_rx <= {r_rx[6:0], i_miso};
            end
            if (i_start) begin
                r_active <= 1'b1;
                r_phase  <= 1'b0;
                r_div    <= '0;
                r_sclk   <= 1'b0;
                r_mosi   <= i_data[31];
                r_shift  <= {i_data[30:0], 1'b0};
                r_bits   <= i_nbits;
            end else if (r_active) begin
                if (w_div_end) begin
                    r_div <= '0;
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                        r_sclk  <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        r_sclk  <= 1'b0;
                        if (r_bits == 6'd1) begin
                            r_active <= 1'b0;
                            r_mosi   <= 1'b0;
                        end else begin
                            r_bits  <= r_bits - 6'd1;
                            r_mosi  <= r_shift[31];
                            r_shift <= {r_shift[30:0], 1'b0};
                        end
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_stream.sv
// spi_flash_stream
// Sequential byte reader for SPI NOR flash (mode 0). A read opens a stream
// (CS_n stays low); a following read of the next address clocks just one
// more byte, any other address closes the stream and re-issues the command.
// Optional build macro SPI_FLASH_WAKE_EN: after the startup wait, send the
// release-power-down opcode and wait STARTUP_WAIT/100 cycles before IDLE.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   spi_sclk/spi_cs_n/spi_mosi/miso  flash interface
//   addr, rd                         byte address and read request
//   dout, data_ready                 last byte and its valid flag
//   busy                             high while rd cannot be accepted
//   terminate                        close the open stream
module spi_flash_stream
    import spi_flash_pkg::*;
#(
    parameter int STARTUP_WAIT = 10000000,
    parameter int CLK_DIV      = 1,
    parameter int ADDR_W       = 24,
    parameter int FAST_READ    = 0,
    parameter int CS_HIGH      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    output logic [7:0]        dout,
    output logic              data_ready,
    output logic              busy,
    input  logic              terminate
);

    localparam int WAKE_GAP = (STARTUP_WAIT / 100 > 0) ? STARTUP_WAIT / 100 : 1;

    state_t            r_state;
    logic [31:0]       r_cnt;
    logic [ADDR_W-1:0] r_addr;     // current address, next_addr once a byte is out
    logic              r_cs_n;
    logic              r_busy;
    logic              r_dr;
    logic [7:0]        r_dout;
    logic              r_kick;     // start the segment of the state just entered
    logic              r_fin;      // byte shifted in; publish it this cycle
    logic              r_reissue;
    logic              r_wake;

    logic              w_start;
    logic [31:0]       w_ld_data;
    logic [5:0]        w_ld_bits;
    logic              w_done;
    logic [7:0]        w_rx;
    logic [7:0]        w_opcode;
    logic [31:0]       w_addr_al;
    logic [31:0]       w_gap_len;

    assign w_opcode  = r_wake ? OP_WAKE : ((FAST_READ != 0) ? OP_FAST_READ : OP_READ);
    assign w_addr_al = 32'(r_addr) << (32 - ADDR_W);
    assign w_gap_len = r_wake ? 32'(WAKE_GAP) : 32'(CS_HIGH);

    // Segments are chained on the engine's done cycle so the bit stream of
    // one transaction has no idle clk cycles between CMD/ADDR/DUMMY/DATA.
    always_comb begin
        w_start   = 1'b0;
        w_ld_data = '0;
        w_ld_bits = 6'(DATA_BITS);
        if (r_kick) begin
            w_start = 1'b1;
            if (r_state == ST_CMD) begin
                w_ld_data = {w_opcode, 24'h0};
            end
        end else if (w_done) begin
            case (r_state)
                ST_CMD: begin
                    if (!r_wake) begin
                        w_start   = 1'b1;
                        w_ld_data = w_addr_al;
                        w_ld_bits = 6'(ADDR_W);
                    end
                end
                ST_ADDR:  begin
                    w_start   = 1'b1;
                    w_ld_bits = 6'(DUMMY_BITS);
                end
                ST_DUMMY: w_start = 1'b1;
                default:  ;
            endcase
        end
    end

    spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_start),
        .i_data  (w_ld_data),
        .i_nbits (w_ld_bits),
        .i_miso  (spi_miso),
        .o_sclk  (spi_sclk),
        .o_mosi  (spi_mosi),
        .o_done  (w_done),
        .o_rx    (w_rx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_INIT;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b1;
            r_dr      <= 1'b0;
            r_dout    <= '0;
            r_kick    <= 1'b0;
            r_fin     <= 1'b0;
            r_reissue <= 1'b0;
            r_wake    <= 1'b0;
        end else begin
            r_kick <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    if (r_cnt + 32'd1 >= 32'(STARTUP_WAIT)) begin
                        r_cnt <= '0;
`ifdef SPI_FLASH_WAKE_EN
                        r_state <= ST_CMD;
                        r_cs_n  <= 1'b0;
                        r_kick  <= 1'b1;
                        r_wake  <= 1'b1;
`else
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_IDLE: begin
                    if (rd) begin
                        r_addr  <= addr;
                        r_busy  <= 1'b1;
                        r_dr    <= 1'b0;
                        r_cs_n  <= 1'b0;
                        r_state <= ST_CMD;
                        r_kick  <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (w_done) begin
                        if (r_wake) begin
                            r_cs_n  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= ST_GAP;
                        end else begin
                            r_state <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_done) begin
                        r_state <= (FAST_READ != 0) ? ST_DUMMY : ST_DATA;
                    end
                end
                ST_DUMMY: begin
                    if (w_done) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_done) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_fin   <= 1'b1;
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (r_fin) begin
                        r_fin  <= 1'b0;
                        r_dout <= w_rx;
                        r_dr   <= 1'b1;
                        r_busy <= 1'b0;
                    end else if (rd) begin
                        r_busy <= 1'b1;
                        r_dr   <= 1'b0;
                        if (addr == r_addr) begin
                            r_state <= ST_DATA;
                            r_kick  <= 1'b1;
                        end else begin
                            r_addr    <= addr;
                            r_reissue <= 1'b1;
                            r_cs_n    <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= ST_GAP;
                        end
                    end else if (terminate) begin
                        r_busy    <= 1'b1;
                        r_cs_n    <= 1'b1;
                        r_reissue <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_cnt + 32'd1 >= w_gap_len) begin
                        r_cnt <= '0;
                        if (r_reissue) begin
                            r_reissue <= 1'b0;
                            r_cs_n    <= 1'b0;
                            r_kick    <= 1'b1;
                            r_state   <= ST_CMD;
                        end else begin
                            r_wake  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign spi_cs_n   = r_cs_n;
    assign dout       = r_dout;
    assign data_ready = r_dr;
    assign busy       = r_busy;

endmodule

// File: tb/tb_spi_flash_stream.sv
`timescale 1ns/1ps
module tb_spi_flash_stream;

    localparam int SW  = 20;
    localparam int CSH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] addr_s [2];
    logic        rd_s   [2];
    logic        term_s [2];
    wire         sclk_w [2];
    wire         cs_w   [2];
    wire         mosi_w [2];
    wire         miso_w [2];
    wire  [7:0]  dout_w [2];
    wire         dr_w   [2];
    wire         busy_w [2];

    // Flash model observations, one element per device
    wire [31:0]  m_n      [2];
    wire [31:0]  m_falls  [2];
    wire [31:0]  m_cshigh [2];
    wire [31:0]  m_per    [2];
    wire [7:0]   m_op     [2];
    wire [23:0]  m_fa     [2];
    wire         m_dum    [2];

    int checks = 0;
    int failures = 0;
    bit          open_s [2];
    logic [23:0] nxt_s  [2];

    spi_flash_stream #(.STARTUP_WAIT(SW), .CLK_DIV(1), .ADDR_W(24), .FAST_READ(0), .CS_HIGH(CSH)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .spi_sclk(sclk_w[0]), .spi_cs_n(cs_w[0]), .spi_mosi(mosi_w[0]),
        .spi_miso(miso_w[0]), .addr(addr_s[0]), .rd(rd_s[0]), .dout(dout_w[0]), .data_ready(dr_w[0]),
        .busy(busy_w[0]), .terminate(term_s[0]));

    spi_flash_stream #(.STARTUP_WAIT(SW), .CLK_DIV(2), .ADDR_W(24), .FAST_READ(1), .CS_HIGH(CSH)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .spi_sclk(sclk_w[1]), .spi_cs_n(cs_w[1]), .spi_mosi(mosi_w[1]),
        .spi_miso(miso_w[1]), .addr(addr_s[1]), .rd(rd_s[1]), .dout(dout_w[1]), .data_ready(dr_w[1]),
        .busy(busy_w[1]), .terminate(term_s[1]));

    // Flash contents as a pure function of the byte address
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (a == 24'h012345) return 8'hA5;
        return 8'(a[7:0] * 8'd29) ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h6C;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_flash
            localparam int HDR = 32 + ((gi == 1) ? 8 : 0);
            int          n = 0;
            int          falls = 0;
            int          cs_high = 0;
            int          per = 0;
            time         t_rise = 0;
            time         t_prev = 0;
            logic [31:0] hdr = '0;
            logic [7:0]  op = '0;
            logic [23:0] fa = '0;
            logic        dum_err = 1'b0;
            logic        miso_r = 1'b0;

            assign miso_w[gi]   = miso_r;
            assign m_n[gi]      = n;
            assign m_falls[gi]  = falls;
            assign m_cshigh[gi] = cs_high;
            assign m_per[gi]    = per;
            assign m_op[gi]     = op;
            assign m_fa[gi]     = fa;
            assign m_dum[gi]    = dum_err;

            always @(posedge sclk_w[gi] or posedge cs_w[gi]) begin
                if (cs_w[gi]) begin
                    n = 0;
                end else begin
                    per = int'(($time - t_prev) / 10);
                    t_prev = $time;
                    n = n + 1;
                    if (n <= 32) hdr = {hdr[30:0], mosi_w[gi]};
                    if (n == 8) op = hdr[7:0];
                    if (n == 32) fa = hdr[23:0];
                    if (n > 32 && n <= HDR && mosi_w[gi] !== 1'b0) dum_err = 1'b1;
                end
            end

            always @(negedge sclk_w[gi]) begin
                int d;
                logic [7:0] b;
                if (!cs_w[gi] && n >= HDR) begin
                    d = n - HDR;
                    b = mem_byte(24'(fa + 24'(d / 8)));
                    miso_r = b[7 - (d % 8)];
                end
            end

            always @(posedge cs_w[gi]) t_rise = $time;
            always @(negedge cs_w[gi]) begin
                falls = falls + 1;
                if (t_rise != 0) cs_high = int'(($time - t_rise) / 10);
            end
        end
    endgenerate

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int d, input string tag);
        int k = 0;
        while (busy_w[d] !== 1'b0 && k < 3000) begin tick(); k++; end
        if (busy_w[d] !== 1'b0) chk({tag, "_busy_timeout"}, 64'(busy_w[d]), 64'd0);
    endtask

    // One read, expectations derived from the stream rules of the device
    task automatic rd_txn(input int d, input logic [23:0] a, input string tag);
        int k, div, bb, exp_lat, f0, n0;
        bit seq, reis;
        div  = (d == 0) ? 1 : 2;
        bb   = 8 + 24 + 8 + ((d == 1) ? 8 : 0);
        seq  = open_s[d] && (a == nxt_s[d]);
        reis = open_s[d] && !seq;
        exp_lat = seq ? (2 * div * 8 + 2) : ((reis ? CSH : 0) + 2 * div * bb + 2);
        wait_idle(d, tag);
        f0 = int'(m_falls[d]);
        n0 = int'(m_n[d]);
        addr_s[d] = a;
        rd_s[d] = 1'b1;
        tick();
        rd_s[d] = 1'b0;
        k = 0;
        while (dr_w[d] !== 1'b1 && k < 3000) begin tick(); k++; end
        chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
        chk({tag, "_dout"}, 64'(dout_w[d]), 64'(mem_byte(a)));
        chk({tag, "_cs_low"}, 64'(cs_w[d]), 64'd0);
        if (seq) begin
            chk({tag, "_no_new_cs"}, 64'(m_falls[d]), 64'(f0));
            chk({tag, "_sclk_count"}, 64'(m_n[d]), 64'(n0 + 8));
        end else begin
            chk({tag, "_cs_falls"}, 64'(m_falls[d]), 64'(f0 + 1));
            chk({tag, "_opcode"}, 64'(m_op[d]), (d == 0) ? 64'h03 : 64'h0B);
            chk({tag, "_addr"}, 64'(m_fa[d]), 64'(a));
            chk({tag, "_sclk_count"}, 64'(m_n[d]), 64'(bb));
        end
        if (reis) chk({tag, "_cs_high"}, 64'(m_cshigh[d]), 64'(CSH));
        $display("txn dev=%0d addr=%06h seq=%0d reissue=%0d lat=%0d dout=%02h", d, a, seq, reis, k, dout_w[d]);
        open_s[d] = 1'b1;
        nxt_s[d]  = a + 24'd1;
    endtask

    task automatic startup_chk(input string tag);
        int k = 0;
        int f0 = int'(m_falls[0]);
        reset_n = 1'b1;
        while (busy_w[0] !== 1'b0 && k < 1000) begin tick(); k++; end
`ifdef SPI_FLASH_WAKE_EN
        chk({tag, "_busy_until_wake"}, 64'(k > SW + 16), 64'd1);
        chk({tag, "_wake_op"}, 64'(m_op[0]), 64'hAB);
        chk({tag, "_wake_cs"}, 64'(m_falls[0]), 64'(f0 + 1));
`else
        chk({tag, "_busy_window"}, 64'(k >= SW && k <= SW + 2), 64'd1);
        chk({tag, "_no_cs_activity"}, 64'(m_falls[0]), 64'(f0));
`endif
        chk({tag, "_cs_idle"}, 64'(cs_w[0]), 64'd1);
        $display("startup %s busy_low_after=%0d", tag, k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] a;
        logic [7:0]  d0;
        int k;
        for (int i = 0; i < 2; i++) begin
            addr_s[i] = '0; rd_s[i] = 1'b0; term_s[i] = 1'b0;
            open_s[i] = 1'b0; nxt_s[i] = '0;
        end
        repeat (3) tick();
        chk("rst_cs_n", 64'(cs_w[0]), 64'd1);
        chk("rst_sclk", 64'(sclk_w[0]), 64'd0);
        chk("rst_mosi", 64'(mosi_w[0]), 64'd0);
        chk("rst_dout", 64'(dout_w[0]), 64'd0);
        chk("rst_dready", 64'(dr_w[0]), 64'd0);
        chk("rst_busy", 64'(busy_w[0]), 64'd1);
        chk("rst_busy1", 64'(busy_w[1]), 64'd1);
        startup_chk("boot");

        rd_txn(0, 24'h012345, "first");
        rd_txn(0, 24'h012346, "seq");
        rd_txn(0, 24'h000100, "nonseq");
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) a = nxt_s[0];
            else a = 24'($urandom);
            rd_txn(0, a, "rand0");
        end

        // wrap-around is still a sequential access
        rd_txn(0, 24'hFFFFFF, "wrap_hi");
        rd_txn(0, 24'h000000, "wrap_lo");

        // terminate closes the stream but keeps the last byte
        d0 = dout_w[0];
        term_s[0] = 1'b1;
        tick();
        term_s[0] = 1'b0;
        chk("term_cs_high", 64'(cs_w[0]), 64'd1);
        k = 0;
        while (busy_w[0] !== 1'b0 && k < 100) begin tick(); k++; end
        chk("term_busy_cycles", 64'(k), 64'(CSH));
        chk("term_dout_kept", 64'(dout_w[0]), 64'(d0));
        chk("term_dready_kept", 64'(dr_w[0]), 64'd1);
        $display("terminate dev=0 busy_low_after=%0d dout=%02h", k, dout_w[0]);
        open_s[0] = 1'b0;
        rd_txn(0, 24'h000001, "after_term");

        // fast read, divided clock
        rd_txn(1, 24'h000000, "fast");
        chk("fast_dummy_zero", 64'(m_dum[1]), 64'd0);
        chk("fast_sclk_period", 64'(m_per[1]), 64'd4);
        rd_txn(1, 24'h000001, "fast_seq");
        for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 1) == 1) a = nxt_s[1];
            else a = 24'($urandom);
            rd_txn(1, a, "rand1");
        end

        // reset in the middle of the address phase
        wait_idle(0, "mid_rst");
        addr_s[0] = 24'h00ABCD;
        rd_s[0] = 1'b1;
        tick();
        rd_s[0] = 1'b0;
        repeat (30) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_cs_n", 64'(cs_w[0]), 64'd1);
        chk("midrst_sclk", 64'(sclk_w[0]), 64'd0);
        chk("midrst_busy", 64'(busy_w[0]), 64'd1);
        chk("midrst_dready", 64'(dr_w[0]), 64'd0);
        $display("reset asserted mid-address cs_n=%0d sclk=%0d", cs_w[0], sclk_w[0]);
        open_s[0] = 1'b0;
        open_s[1] = 1'b0;
        tick();
        startup_chk("reboot");
        rd_txn(0, 24'h012345, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
